// File: rtl/merge_output_packer.sv
// Sink stage after the merger tree: packs LANES sorted records per memory beat,
// counts records against the expected total, masks the final partial beat,
// and flags order violations and dropped writes.
module merge_output_packer #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4,
    parameter int CNT_W  = 32
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [CNT_W-1:0]         i_total,
    input  logic                     i_write,
    input  logic [DATA_W-1:0]        i_data,
    output logic                     o_ready,
    output logic                     o_mem_valid,
    input  logic                     i_mem_ready,
    output logic [DATA_W*LANES-1:0]  o_mem_data,
    output logic [LANES-1:0]         o_mem_mask,
    output logic                     o_mem_last,
    output logic                     o_done,
    output logic                     o_order_err,
    output logic                     o_overrun,
    output logic [CNT_W-1:0]         o_beats
);

    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                    state_reg, state_next;
    logic [CNT_W-1:0]          remaining_reg;
    logic [LANE_W-1:0]         lane_reg;
    logic [DATA_W-1:0]         pack_reg [LANES];
    logic [DATA_W-1:0]         prev_reg;
    logic                      have_prev_reg;
    logic                      mem_valid_reg;
    logic [DATA_W*LANES-1:0]   mem_data_reg;
    logic [LANES-1:0]          mem_mask_reg;
    logic                      mem_last_reg;
    logic                      done_reg;
    logic                      order_err_reg;
    logic                      overrun_reg;
    logic [CNT_W-1:0]          beats_reg;

    logic                      completing;
    logic                      ready_c;
    logic                      accept;
    logic                      handshake;
    logic                      start_ok;
    logic                      last_record;
    logic [DATA_W*LANES-1:0]   beat_word;
    logic [LANES-1:0]          beat_mask;
    logic [DATA_W-1:0]         lane_val [LANES];

    assign last_record = (remaining_reg == CNT_W'(1));
    assign completing  = (lane_reg == LANE_W'(LANES-1)) || last_record;
    // A beat-completing record may only enter when the output slot is free or freeing.
    assign ready_c     = (state_reg == RUN) && (!completing || !mem_valid_reg || i_mem_ready);
    assign accept      = i_write && ready_c;
    assign handshake   = mem_valid_reg && i_mem_ready;
    assign start_ok    = i_start && ((state_reg == IDLE) || (state_reg == DONE));

    // Beat image as it would look if the current record completes it:
    // earlier lanes from the pack register, current lane from the input, rest zero.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_val[gi] = (gi == int'(lane_reg)) ? i_data :
                                  (gi <  int'(lane_reg)) ? pack_reg[gi] : '0;
            assign beat_word[gi*DATA_W +: DATA_W] = lane_val[gi];
            assign beat_mask[gi] = (gi <= int'(lane_reg));

            // Capture an accepted record into its lane slot.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    pack_reg[gi] <= '0;
                end else if (accept && (int'(lane_reg) == gi)) begin
                    pack_reg[gi] <= i_data;
                end
            end
        end
    endgenerate

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: RUN until the final record, DRAIN until its beat leaves.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (i_start) begin
                    state_next = (i_total == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (accept && last_record) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (handshake) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: counters, beat register, sticky flags.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            remaining_reg <= '0;
            lane_reg      <= '0;
            prev_reg      <= '0;
            have_prev_reg <= 1'b0;
            mem_valid_reg <= 1'b0;
            mem_data_reg  <= '0;
            mem_mask_reg  <= '0;
            mem_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            order_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            beats_reg     <= '0;
        end else begin
            done_reg <= (state_next == DONE);

            if (start_ok) begin
                remaining_reg <= i_total;
                lane_reg      <= '0;
                beats_reg     <= '0;
                order_err_reg <= 1'b0;
                overrun_reg   <= 1'b0;
                have_prev_reg <= 1'b0;
            end

            // Placed after the start clear so a write dropped alongside a start still registers.
            if (i_write && !ready_c) begin
                overrun_reg <= 1'b1;
            end

            if (handshake) begin
                beats_reg     <= beats_reg + CNT_W'(1);
                mem_valid_reg <= 1'b0;
            end

            if (accept) begin
                prev_reg      <= i_data;
                have_prev_reg <= 1'b1;
                if (have_prev_reg && (i_data < prev_reg)) begin
                    order_err_reg <= 1'b1;
                end
                remaining_reg <= remaining_reg - CNT_W'(1);
                if (completing) begin
                    mem_data_reg  <= beat_word;
                    mem_mask_reg  <= beat_mask;
                    mem_valid_reg <= 1'b1;
                    mem_last_reg  <= last_record;
                    lane_reg      <= '0;
                end else begin
                    lane_reg <= lane_reg + LANE_W'(1);
                end
            end
        end
    end

    assign o_ready     = ready_c;
    assign o_mem_valid = mem_valid_reg;
    assign o_mem_data  = mem_data_reg;
    assign o_mem_mask  = mem_mask_reg;
    assign o_mem_last  = mem_last_reg;
    assign o_done      = done_reg;
    assign o_order_err = order_err_reg;
    assign o_overrun   = overrun_reg;
    assign o_beats     = beats_reg;

endmodule

// File: doc/merge_output_packer.md
Name: merge_output_packer

Overview:
- Sink stage directly downstream of the 4-input merger tree.
- Consumes the tree's sorted 32-bit output stream (write strobe plus data) and provides the tree's output-ready input.
- Packs LANES consecutive records into one wide memory beat with a valid/ready handshake.
- Tracks the expected record count, emits a masked final partial beat, flags order violations and dropped writes, and signals completion.

Parameters:
- DATA_W, 32, record width in bits.
- LANES, 4, records per output beat.
- CNT_W, 32, width of record and beat counters.

Ports:
- i_clk  input  1  clock; all logic is on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_start  input  1  begin a run; honoured in IDLE or DONE only.
- i_total  input  CNT_W  number of records expected; sampled when i_start is accepted.
- i_write  input  1  record strobe from the merger tree.
- i_data  input  DATA_W  record value from the merger tree.
- o_ready  output  1  to the merger tree's output-ready input.
- o_mem_valid  output  1  beat valid.
- i_mem_ready  input  1  memory accepts the beat.
- o_mem_data  output  DATA_W*LANES  packed beat; lane k occupies bits [DATA_W*(k+1)-1 : DATA_W*k].
- o_mem_mask  output  LANES  lane-valid mask.
- o_mem_last  output  1  final beat of the run.
- o_done  output  1  run complete (level).
- o_order_err  output  1  sticky; a record was smaller than its predecessor.
- o_overrun  output  1  sticky; i_write was asserted while o_ready was low.
- o_beats  output  CNT_W  beats handed to memory in this run.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - o_ready, o_mem_valid, o_mem_last, o_done, o_order_err, o_overrun = 0.
  - o_mem_data = 0, o_mem_mask = 0, o_beats = 0.
  - Lane counter, record counter and the "previous record" register are cleared.
  - Reset mid-run discards the partial pack and any pending beat.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with i_start = 1:
  - Latch i_total into remaining.
  - Clear lane counter, o_beats, o_order_err, o_overrun and o_done.
  - Next state is RUN, or DONE directly if i_total = 0; no beat is emitted in that case.
- RUN acceptance:
  - completing = (lane == LANES-1) or (remaining == 1).
  - o_ready = (state == RUN) and (!completing or !o_mem_valid or i_mem_ready). This is combinational.
  - A record is accepted when i_write and o_ready are both high.
  - On accept: the record is written into lane[lane], lane increments, remaining decrements.
- Completing accept:
  - The pack register with the new record is copied into o_mem_data on the same edge.
  - o_mem_mask gets ones for lanes 0..lane.
  - o_mem_valid = 1.
  - o_mem_last = 1 if remaining was 1.
  - Lane resets to 0; unused lanes are driven to 0.
  - Latency: the beat is visible the cycle after the edge that accepted the last record of the beat.
- Output handshake:
  - A beat holds stable while o_mem_valid = 1 and i_mem_ready = 0.
  - On o_mem_valid and i_mem_ready, o_beats increments. o_mem_valid drops unless a new beat is loaded on the same edge; back-to-back beats are allowed.
- Finishing the run:
  - When the final record is accepted, the state goes to DRAIN.
  - DRAIN → DONE when the last beat is accepted. o_done = 1 in DONE until the next accepted i_start.
- Order check:
  - Each accepted record is compared, unsigned, with the previous accepted record of the same run.
  - If the new record is smaller, o_order_err is set; it is sticky until start or reset.
  - The first record of a run is never an error. Equal values are legal.
- Dropped writes: i_write while o_ready = 0, in any state, drops the record and sets o_overrun (sticky). Counters do not change.
- Ignored start: i_start in RUN or DRAIN is ignored.
- Simultaneous start and write in IDLE: the write is dropped (overrun), because o_ready is 0 in IDLE.

Test Plan:
- Full beats:
  - Stimulus: i_total = 8; records 1..8 on consecutive cycles; i_mem_ready = 1.
  - Required: two beats, data {4,3,2,1} and {8,7,6,5} (lane 3..0), mask 4'b1111, o_mem_last on the second beat only, o_beats = 2, o_done high, no error flags.
- Partial final beat:
  - Stimulus: i_total = 6, records 10..15.
  - Required: second beat data {0,0,15,14}, mask 4'b0011, o_mem_last = 1.
- Backpressure:
  - Stimulus: i_total = 8, i_mem_ready = 0 for 5 cycles after the first beat.
  - Required: o_ready falls only when the 8th record would complete a beat; the first beat is held stable throughout; no overrun; both beats are delivered in order.
- Order violation and overrun:
  - Stimulus: i_total = 4, records 5, 7, 6, 9; plus one i_write while o_ready = 0.
  - Required: o_order_err = 1 after record 6; o_overrun = 1; beat {9,6,7,5} is still emitted.
- Zero total and restart:
  - Stimulus: i_start with i_total = 0, then i_start with i_total = 4.
  - Required: DONE one cycle after the first start with no beat; the second run completes normally with o_beats = 1.
- Reset mid-run:
  - Stimulus: assert i_rst after 2 of 4 records.
  - Required: all outputs return to their reset values on the next edge, and no beat is emitted.
